// File: rtl/controller_sysid_checker.sv
// -----------------------------------------------------------------------------
// controller_sysid_checker
//
// Avalon-MM read master placed directly downstream of the controller's
// system-ID slave. A start pulse launches two single-word reads: word 0
// (system ID) and word 1 (build timestamp). Both are captured and compared
// against build-time constants. The result is held on pass/fail until the next
// accepted start or reset. Every read has its own timeout so that a dead or
// absent slave cannot hang the boot/supervisor logic.
//
// Build option:
//   SYSID_CHECK_TIMESTAMP_EN  defined   : ID and timestamp must both match.
//                             undefined : the timestamp is still read and
//                                         captured, but only the ID decides
//                                         pass/fail.
//
// Ports:
//   clock              in   1   system clock, rising edge
//   reset              in   1   synchronous, active-high reset
//   start              in   1   one-cycle pulse, accepted only when idle
//   avm_address        out  1   0 = ID word, 1 = timestamp word
//   avm_read           out  1   read request
//   avm_waitrequest    in   1   slave stall, request is held while high
//   avm_readdata       in   32  read data
//   avm_readdatavalid  in   1   readdata qualifier
//   busy               out  1   high from accepted start until done
//   done               out  1   one-cycle pulse at the end of a check
//   pass               out  1   sticky: compare matched
//   fail               out  1   sticky: mismatch or timeout
//   timeout            out  1   sticky: fail was caused by a timeout
//   id_value           out  32  last captured ID word
//   ts_value           out  32  last captured timestamp word
// -----------------------------------------------------------------------------
`default_nettype none

module controller_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd49153,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1531293970,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // FSM encoding
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ID_REQ  = 3'd1;
    localparam logic [2:0] S_ID_WAIT = 3'd2;
    localparam logic [2:0] S_TS_REQ  = 3'd3;
    localparam logic [2:0] S_TS_WAIT = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;

    // The counter holds the number of cycles already spent on the current
    // read, so the last permitted cycle is the one where it equals
    // TIMEOUT_CYCLES-1.
    localparam logic [15:0] C_LAST_CYCLE = 16'(TIMEOUT_CYCLES - 1);

`ifdef SYSID_CHECK_TIMESTAMP_EN
    localparam bit TS_COMPARE_EN = 1'b1;
`else
    localparam bit TS_COMPARE_EN = 1'b0;
`endif

    // Match decision on the captured words. With the timestamp compare
    // disabled the second term collapses to 1 at elaboration time.
    function automatic logic f_match(input logic [31:0] id_word,
                                     input logic [31:0] ts_word);
        logic id_ok;
        logic ts_ok;
        id_ok   = (id_word == EXPECTED_ID);
        ts_ok   = (!TS_COMPARE_EN) || (ts_word == EXPECTED_TIMESTAMP);
        f_match = id_ok && ts_ok;
    endfunction

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic [31:0] r_id;
    logic [31:0] r_ts;

    logic        w_in_req;
    logic        w_in_wait;
    logic        w_accept;
    logic        w_complete;
    logic        w_last_cycle;
    logic [15:0] w_cnt_inc;

    assign w_in_req  = (r_state == S_ID_REQ)  || (r_state == S_TS_REQ);
    assign w_in_wait = (r_state == S_ID_WAIT) || (r_state == S_TS_WAIT);

    // A request is taken by the slave when it is presented and not stalled.
    assign w_accept = w_in_req && !avm_waitrequest;

    // A read completes either in its WAIT state or, for a zero-latency slave,
    // in the very cycle the request is accepted. readdatavalid seen anywhere
    // else (IDLE, stalled REQ, CHECK) is deliberately ignored.
    assign w_complete = avm_readdatavalid && (w_in_wait || w_accept);

    assign w_last_cycle = (r_cnt == C_LAST_CYCLE);
    assign w_cnt_inc    = r_cnt + 16'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
            r_id      <= 32'd0;
            r_ts      <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_ID_REQ;
                        r_cnt     <= 16'd0;
                        r_pass    <= 1'b0;
                        r_fail    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end

                // Completion is tested before the limit so that data arriving
                // on the last permitted cycle still counts.
                S_ID_REQ, S_ID_WAIT: begin
                    if (w_complete) begin
                        r_id    <= avm_readdata;
                        r_state <= S_TS_REQ;
                        r_cnt   <= 16'd0;
                    end else if (w_last_cycle) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= 16'd0;
                        r_fail    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        if (w_accept) begin
                            r_state <= S_ID_WAIT;
                        end
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_TS_REQ, S_TS_WAIT: begin
                    if (w_complete) begin
                        r_ts    <= avm_readdata;
                        r_state <= S_CHECK;
                        r_cnt   <= 16'd0;
                    end else if (w_last_cycle) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= 16'd0;
                        r_fail    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        if (w_accept) begin
                            r_state <= S_TS_WAIT;
                        end
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_CHECK: begin
                    r_pass  <= f_match(r_id, r_ts);
                    r_fail  <= !f_match(r_id, r_ts);
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

    // The request and address are decoded from state only, so they cannot
    // change while the slave is stalling (the state holds in REQ).
    assign avm_read    = w_in_req;
    assign avm_address = (r_state == S_TS_REQ) || (r_state == S_TS_WAIT);

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign timeout  = r_timeout;
    assign id_value = r_id;
    assign ts_value = r_ts;

endmodule

`default_nettype wire

// File: tb/tb_controller_sysid_checker.sv
`timescale 1ns/1ps

module tb_controller_sysid_checker;

    localparam logic [31:0] GOOD_ID = 32'd49153;
    localparam logic [31:0] GOOD_TS = 32'd1531293970;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int n_checks = 0;
    int n_fail   = 0;

    // slave model configuration
    int          cfg_wait    = 0;
    int          cfg_lat     = 1;
    bit          cfg_respond = 1'b1;
    logic [31:0] cfg_id      = GOOD_ID;
    logic [31:0] cfg_ts      = GOOD_TS;

    // monitor state
    int   done_cnt = 0;
    int   stab_err = 0;
    int   n_acc    = 0;
    logic addr_log [4];

    always #5 clock = ~clock;

    controller_sysid_checker #(
        .EXPECTED_ID        (GOOD_ID),
        .EXPECTED_TIMESTAMP (GOOD_TS),
        .TIMEOUT_CYCLES     (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .fail              (fail),
        .timeout           (timeout),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Avalon slave: holds waitrequest for cfg_wait cycles per request, then
    // returns data cfg_lat cycles after acceptance (0 = same cycle).
    initial begin
        bit   s_acc;
        logic s_addr;
        bit   pend;
        int   rem;
        int   wcnt;
        logic raddr;
        pend = 1'b0; rem = 0; wcnt = 0; raddr = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        forever begin
            @(negedge clock);
            s_acc  = (avm_read === 1'b1) && (avm_waitrequest === 1'b0);
            s_addr = avm_address;
            @(posedge clock); #1;
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
            if (s_acc) begin
                wcnt = 0;
                if (cfg_lat > 0 && cfg_respond) begin
                    pend = 1'b1; rem = cfg_lat; raddr = s_addr;
                end
            end
            if (pend) begin
                rem--;
                if (rem == 0) begin
                    pend = 1'b0;
                    avm_readdatavalid = 1'b1;
                    avm_readdata = raddr ? cfg_ts : cfg_id;
                end
            end
            if (avm_read === 1'b1) begin
                if (wcnt < cfg_wait) begin
                    avm_waitrequest = 1'b1;
                    wcnt++;
                end else if (cfg_lat == 0 && cfg_respond) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = avm_address ? cfg_ts : cfg_id;
                end
            end
        end
    end

    // Bus monitor: done pulses, request stability under stall, accepted addresses.
    initial begin
        logic prev_read, prev_wait, prev_addr;
        prev_read = 1'b0; prev_wait = 1'b0; prev_addr = 1'b0;
        forever begin
            @(negedge clock);
            if (done === 1'b1) done_cnt++;
            if (prev_read && prev_wait)
                if (avm_read !== 1'b1 || avm_address !== prev_addr) stab_err++;
            if (avm_read === 1'b1 && avm_waitrequest === 1'b0) begin
                addr_log[n_acc % 4] = avm_address;
                n_acc++;
            end
            prev_read = (avm_read === 1'b1);
            prev_wait = (avm_waitrequest === 1'b1);
            prev_addr = avm_address;
        end
    end

    // Pulse start and return the cycle (start cycle = 0) in which done is seen.
    task automatic run_check(output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                got = 1'b1;
                lat = i;
            end else begin
                @(posedge clock); #1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int d0;
        bit found;

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_eq("rst_busy",    busy,        0);
        chk_eq("rst_done",    done,        0);
        chk_eq("rst_pass",    pass,        0);
        chk_eq("rst_fail",    fail,        0);
        chk_eq("rst_timeout", timeout,     0);
        chk_eq("rst_read",    avm_read,    0);
        chk_eq("rst_addr",    avm_address, 0);
        chk_eq("rst_id",      id_value,    0);
        chk_eq("rst_ts",      ts_value,    0);
        @(posedge clock); #1 reset = 1'b0;

        // baseline: zero wait, 1-cycle latency, matching image
        n_acc = 0; d0 = done_cnt;
        run_check(lat);
        chk_eq("base_lat",     lat,      6);
        chk_eq("base_pass",    pass,     1);
        chk_eq("base_fail",    fail,     0);
        chk_eq("base_timeout", timeout,  0);
        chk_eq("base_id",      id_value, GOOD_ID);
        chk_eq("base_ts",      ts_value, GOOD_TS);
        chk_eq("base_busy",    busy,     0);
        chk_eq("base_nacc",    n_acc,    2);
        chk_eq("base_addr0",   addr_log[0], 0);
        chk_eq("base_addr1",   addr_log[1], 1);
        repeat (3) @(posedge clock);
        chk_eq("base_one_done", done_cnt - d0, 1);

        // wrong ID
        cfg_id = 32'd49154;
        run_check(lat);
        chk_eq("badid_lat",     lat,      6);
        chk_eq("badid_pass",    pass,     0);
        chk_eq("badid_fail",    fail,     1);
        chk_eq("badid_timeout", timeout,  0);
        chk_eq("badid_id",      id_value, 32'd49154);

        // right ID, wrong timestamp
        cfg_id = GOOD_ID; cfg_ts = 32'd0;
        run_check(lat);
        chk_eq("badts_ts", ts_value, 0);
`ifdef SYSID_CHECK_TIMESTAMP_EN
        chk_eq("badts_pass", pass, 0);
        chk_eq("badts_fail", fail, 1);
`else
        chk_eq("badts_pass", pass, 1);
        chk_eq("badts_fail", fail, 0);
`endif
        cfg_ts = GOOD_TS;

        // stalled slave: 3 waitrequest cycles per read
        cfg_wait = 3; cfg_lat = 1; stab_err = 0;
        run_check(lat);
        chk_eq("wait_lat",  lat,      12);
        chk_eq("wait_pass", pass,     1);
        chk_eq("wait_stab", stab_err, 0);

        // zero-latency slave: data in the acceptance cycle
        cfg_wait = 0; cfg_lat = 0;
        run_check(lat);
        chk_eq("zlat_lat",  lat,      4);
        chk_eq("zlat_pass", pass,     1);
        chk_eq("zlat_id",   id_value, GOOD_ID);
        chk_eq("zlat_ts",   ts_value, GOOD_TS);

        // data on the last permitted cycle of each read still completes
        cfg_wait = 6; cfg_lat = 1;
        run_check(lat);
        chk_eq("edge_lat",     lat,     18);
        chk_eq("edge_pass",    pass,    1);
        chk_eq("edge_timeout", timeout, 0);

        // one cycle later is a timeout; the late readdatavalid lands in IDLE
        cfg_wait = 7; d0 = done_cnt;
        run_check(lat);
        chk_eq("late_lat",     lat,      9);
        chk_eq("late_fail",    fail,     1);
        chk_eq("late_timeout", timeout,  1);
        chk_eq("late_pass",    pass,     0);
        chk_eq("late_read",    avm_read, 0);
        repeat (4) @(posedge clock);
        #1;
        chk_eq("late_idle",     busy,          0);
        chk_eq("late_one_done", done_cnt - d0, 1);

        // slave never answers
        cfg_wait = 0; cfg_lat = 1; cfg_respond = 1'b0;
        run_check(lat);
        chk_eq("dead_lat",     lat,      9);
        chk_eq("dead_fail",    fail,     1);
        chk_eq("dead_timeout", timeout,  1);
        chk_eq("dead_read",    avm_read, 0);
        cfg_respond = 1'b1;

        // new start clears sticky results; start while busy is ignored
        d0 = done_cnt;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        chk_eq("restart_fail",    fail,    0);
        chk_eq("restart_timeout", timeout, 0);
        chk_eq("restart_pass",    pass,    0);
        chk_eq("restart_busy",    busy,    1);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        chk_eq("busy_start_dones", done_cnt - d0, 1);
        chk_eq("busy_start_pass",  pass,          1);

        // reset while waiting for the timestamp; its data arrives afterwards
        cfg_lat = 3; d0 = done_cnt; found = 1'b0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clock); #1;
            if (avm_address === 1'b1 && avm_read === 1'b0) found = 1'b1;
        end
        chk_eq("reach_ts_wait", found, 1);
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk_eq("rstmid_done_cnt", done_cnt - d0, 0);
        chk_eq("rstmid_busy",     busy,     0);
        chk_eq("rstmid_read",     avm_read, 0);
        chk_eq("rstmid_pass",     pass,     0);
        chk_eq("rstmid_fail",     fail,     0);
        chk_eq("rstmid_timeout",  timeout,  0);
        chk_eq("rstmid_id",       id_value, 0);
        chk_eq("rstmid_ts",       ts_value, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
